// File: rtl/char_scroll_scan_pkg.sv
// ============================================================================
// char_disp_pkg : shared constants, scan FSM states and virtual-line helper
// Rev 1.0
// ============================================================================
`default_nettype none

package char_disp_pkg;

  localparam int N_ROWS = 7;
  localparam int CHAR_W = 7;
  localparam int TEXT_W = 49;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // Virtual line: WIN blank columns, the text, then WIN blank columns.
  function automatic logic virt_bit(input logic [TEXT_W-1:0] row,
                                    input int                v,
                                    input int                win);
    logic [TEXT_W-1:0] sh;
    logic              b;
    b  = 1'b0;
    sh = '0;
    if (v >= win && v < win + TEXT_W) begin
      sh = row >> (v - win);
      b  = sh[0];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/char_scroll_scan_tick_div.sv
// ============================================================================
// tick_div : free-running modulo-DIV counter with clear, enable and tick
// Rev 1.0
// ============================================================================
`default_nettype none

module tick_div #(
  parameter  int DIV = 4,
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  output logic          tick_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o  = en_i && !clr_i && (cnt_q == LAST);
  assign count_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/char_scroll_scan.sv
// ============================================================================
// char_scroll_scan : row-multiplexed 7xWIN LED scanner with horizontal scroll
// Rev 1.0
// ============================================================================
`default_nettype none

module char_scroll_scan
  import char_disp_pkg::*;
#(
  parameter int SCAN_DIV   = 5000,
  parameter int SCROLL_DIV = 2500000,
  parameter int WIN        = 16,
  parameter int BLANK      = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [TEXT_W-1:0] row1_i,
  input  logic [TEXT_W-1:0] row2_i,
  input  logic [TEXT_W-1:0] row3_i,
  input  logic [TEXT_W-1:0] row4_i,
  input  logic [TEXT_W-1:0] row5_i,
  input  logic [TEXT_W-1:0] row6_i,
  input  logic [TEXT_W-1:0] row7_i,
  input  logic              loop_i,
  output logic [N_ROWS-1:0] row_sel_o,
  output logic [WIN-1:0]    col_data_o,
  output logic              scroll_done_o
);

  localparam int             SCW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int             TCW      = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int             PW       = $clog2(TEXT_W + 2 * WIN);
  localparam logic [PW-1:0]  POS_LAST = PW'(TEXT_W - 1 + WIN);
  localparam logic [2:0]     ROW_LAST = 3'(N_ROWS - 1);

  logic [TEXT_W-1:0] w_rows  [N_ROWS];
  logic [TEXT_W-1:0] frame_q [N_ROWS];
  logic [TEXT_W-1:0] frame_d [N_ROWS];

  scan_state_e       state_q, state_d, w_scroll_state;
  logic [PW-1:0]     pos_q, pos_d, w_scroll_pos;
  logic [2:0]        row_q, row_d;
  logic              pend_q, pend_d, w_scroll_pend;
  logic [N_ROWS-1:0] row_sel_q, row_sel_d;
  logic [WIN-1:0]    col_q, col_d;
  logic              done_q, done_d;

  logic              w_change, w_nonzero, w_boundary, w_wrap, w_lit;
  logic              w_scan_tick, w_scroll_tick;
  logic [SCW-1:0]    w_scan_cnt, w_sc_next;
  logic [TCW-1:0]    w_scroll_cnt_unused;

  assign w_rows[0] = row1_i;
  assign w_rows[1] = row2_i;
  assign w_rows[2] = row3_i;
  assign w_rows[3] = row4_i;
  assign w_rows[4] = row5_i;
  assign w_rows[5] = row6_i;
  assign w_rows[6] = row7_i;

  tick_div #(.DIV(SCAN_DIV)) u_scan_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (1'b0),
    .en_i   (1'b1),
    .tick_o (w_scan_tick),
    .count_o(w_scan_cnt)
  );

  tick_div #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (w_change),
    .en_i   (state_q == ST_SCROLL),
    .tick_o (w_scroll_tick),
    .count_o(w_scroll_cnt_unused)
  );

  always_comb begin
    w_change  = 1'b0;
    w_nonzero = 1'b0;
    for (int r = 0; r < N_ROWS; r++) begin
      if (w_rows[r] != frame_q[r]) w_change  = 1'b1;
      if (w_rows[r] != '0)         w_nonzero = 1'b1;
    end
  end

  // Scroll progression ignoring any content change; the display path uses
  // these values so a pos step never lands inside a lit row slot.
  always_comb begin
    w_boundary     = w_scan_tick && (row_q == ROW_LAST);
    w_scroll_state = state_q;
    w_scroll_pos   = pos_q;
    w_scroll_pend  = pend_q;
    w_wrap         = 1'b0;
    if (state_q == ST_SCROLL) begin
      if (w_boundary && pend_q) begin
        w_scroll_pend = 1'b0;
        if (pos_q == POS_LAST) begin
          w_scroll_pos   = '0;
          w_wrap         = 1'b1;
          w_scroll_state = loop_i ? ST_SCROLL : ST_HOLD;
        end else begin
          w_scroll_pos = pos_q + 1'b1;
        end
      end
      if (w_scroll_tick)               w_scroll_pend = 1'b1;
      if (w_scroll_state == ST_HOLD)   w_scroll_pend = 1'b0;
    end
  end

  always_comb begin
    row_d = row_q;
    if (w_scan_tick) row_d = (row_q == ROW_LAST) ? 3'd0 : row_q + 3'd1;

    state_d = w_scroll_state;
    pos_d   = w_scroll_pos;
    pend_d  = w_scroll_pend;
    frame_d = frame_q;
    if (w_change) begin
      frame_d = w_rows;
      pos_d   = '0;
      pend_d  = 1'b0;
      state_d = w_nonzero ? ST_SCROLL : ST_IDLE;
    end

    w_sc_next = w_scan_tick ? '0 : w_scan_cnt + 1'b1;
    w_lit     = (int'(w_sc_next) >= BLANK);
    row_sel_d = w_lit ? (N_ROWS'(1) << row_d) : '0;
    col_d     = '0;
    if (w_lit && w_scroll_state == ST_SCROLL) begin
      for (int j = 0; j < WIN; j++) begin
        col_d[j] = virt_bit(frame_q[row_d], int'(w_scroll_pos) + j, WIN);
      end
    end
    done_d = w_wrap && !w_change;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N_ROWS; r++) frame_q[r] <= '0;
      state_q   <= ST_IDLE;
      pos_q     <= '0;
      row_q     <= '0;
      pend_q    <= 1'b0;
      row_sel_q <= '0;
      col_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      frame_q   <= frame_d;
      state_q   <= state_d;
      pos_q     <= pos_d;
      row_q     <= row_d;
      pend_q    <= pend_d;
      row_sel_q <= row_sel_d;
      col_q     <= col_d;
      done_q    <= done_d;
    end
  end

  assign row_sel_o     = row_sel_q;
  assign col_data_o    = col_q;
  assign scroll_done_o = done_q;

endmodule

`default_nettype wire
